// File: rtl/pio_channel_bank.sv
// pio_channel_bank: Avalon-MM PIO bank with NUM_CH input and NUM_CH output
// channels. Each channel runs either as a plain level export or as a
// valid/ready mailbox. Sticky overrun flags feed a registered level interrupt.
module pio_channel_bank #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset,
   input  logic [5:0]               avs_address,
   input  logic                     avs_read,
   input  logic                     avs_write,
   input  logic [31:0]              avs_writedata,
   output logic [31:0]              avs_readdata,
   output logic                     avs_readdatavalid,
   output logic                     irq,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready
);

   logic [DATA_W-1:0] in_hold [NUM_CH];
   logic [DATA_W-1:0] out_reg [NUM_CH];

   logic [NUM_CH-1:0] in_full, out_pend, in_mode, out_mode;
   logic [NUM_CH-1:0] irq_en_in, in_ovr, out_ovr;
   logic              irq_en_err;

   logic [NUM_CH-1:0] in_mode_nx, out_mode_nx, in_full_nx, out_pend_nx;
   logic [NUM_CH-1:0] cap, pop, in_ovr_set, acc, wr_out, load, out_ovr_set;
   logic [NUM_CH-1:0] err_clr_in, err_clr_out;
   logic [31:0]       rd_word;
   logic              wr_mode, wr_irq_en, wr_err;
   logic              unused_wdata;

   assign in_ready  = in_mode & ~in_full;
   assign out_valid = out_mode & out_pend;

   assign wr_mode      = avs_write && (avs_address == 6'h21);
   assign wr_irq_en    = avs_write && (avs_address == 6'h22);
   assign wr_err       = avs_write && (avs_address == 6'h23);
   assign unused_wdata = ^avs_writedata;

   // Per-channel handshake strobes and next state of the mailbox flags
   always_comb begin
      in_mode_nx  = wr_mode ? avs_writedata[NUM_CH-1:0]  : in_mode;
      out_mode_nx = wr_mode ? avs_writedata[16 +: NUM_CH] : out_mode;
      err_clr_in  = wr_err  ? avs_writedata[NUM_CH-1:0]  : '0;
      err_clr_out = wr_err  ? avs_writedata[16 +: NUM_CH] : '0;
      cap         = '0;
      pop         = '0;
      in_ovr_set  = '0;
      acc         = '0;
      wr_out      = '0;
      load        = '0;
      out_ovr_set = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         pop[c]        = avs_read && (avs_address[5:4] == 2'b00) &&
                         (avs_address[3:0] == c[3:0]) && in_mode[c];
         cap[c]        = in_valid[c] && in_ready[c];
         in_ovr_set[c] = in_valid[c] && in_mode[c] && in_full[c];
         acc[c]        = out_valid[c] && out_ready[c];
         wr_out[c]     = avs_write && (avs_address[5:4] == 2'b01) &&
                         (avs_address[3:0] == c[3:0]);
         load[c]        = wr_out[c] && !(out_mode[c] && out_pend[c] && !acc[c]);
         out_ovr_set[c] = wr_out[c] &&  (out_mode[c] && out_pend[c] && !acc[c]);
      end
      // Gating with the post-write mode clears a flag in the same update that
      // turns its channel back to level mode; a capture that cycle is lost.
      in_full_nx  = in_mode_nx  & (cap | (in_full & ~pop));
      out_pend_nx = out_mode_nx & ((load & out_mode) | (out_pend & ~acc));
   end

   // Host read multiplexer; unmapped words and absent channels read zero
   always_comb begin
      rd_word = '0;
      case (avs_address[5:4])
         2'b00: begin
            for (int unsigned c = 0; c < NUM_CH; c++)
               if (avs_address[3:0] == c[3:0]) rd_word = 32'(in_hold[c]);
         end
         2'b01: begin
            for (int unsigned c = 0; c < NUM_CH; c++)
               if (avs_address[3:0] == c[3:0]) rd_word = 32'(out_reg[c]);
         end
         2'b10: begin
            case (avs_address[3:0])
               4'h0:    rd_word = {16'(out_pend), 16'(in_full)};
               4'h1:    rd_word = {16'(out_mode), 16'(in_mode)};
               4'h2:    rd_word = {irq_en_err, 15'd0, 16'(irq_en_in)};
               4'h3:    rd_word = {16'(out_ovr), 16'(in_ovr)};
               default: rd_word = '0;
            endcase
         end
         default: rd_word = '0;
      endcase
   end

   // Control/status registers, read response and interrupt
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         in_mode           <= '0;
         out_mode          <= '0;
         irq_en_in         <= '0;
         irq_en_err        <= 1'b0;
         in_full           <= '0;
         out_pend          <= '0;
         in_ovr            <= '0;
         out_ovr           <= '0;
         irq               <= 1'b0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read) avs_readdata <= rd_word;
         in_mode  <= in_mode_nx;
         out_mode <= out_mode_nx;
         if (wr_irq_en) begin
            irq_en_in  <= avs_writedata[NUM_CH-1:0];
            irq_en_err <= avs_writedata[31];
         end
         in_full  <= in_full_nx;
         out_pend <= out_pend_nx;
         in_ovr   <= (in_ovr  & ~err_clr_in)  | in_ovr_set;
         out_ovr  <= (out_ovr & ~err_clr_out) | out_ovr_set;
         irq      <= (|(in_full & irq_en_in)) | (irq_en_err & ((|in_ovr) | (|out_ovr)));
      end
   end

   // Channel data: level inputs sample every cycle, mailboxes capture on handshake
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            in_hold[c] <= '0;
            out_reg[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!in_mode[c] || cap[c]) in_hold[c] <= in_data[c*DATA_W +: DATA_W];
            if (load[c])               out_reg[c] <= avs_writedata[DATA_W-1:0];
         end
      end
   end

   // Flatten the output registers onto the fabric bus
   always_comb begin
      out_data = '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         out_data[c*DATA_W +: DATA_W] = out_reg[c];
   end

endmodule
